// File: rtl/esc_update_scheduler_pkg.sv
// esc_sched_pkg: shared types and constants for the ESC update scheduler.
//   - esc_state_e : scheduler state (ARM, RUN, KILL)
//   - FRNT/BCK/LFT/RGHT : index of each motor in the packed esc_spd bus
//   - SPD_W : width of one motor speed
//   - ESC_MAX_PULSE_CLKS : longest ESC pulse (6250 + 3*2047 clocks)
package esc_sched_pkg;

  localparam int SPD_W              = 11;
  localparam int FRNT               = 0;
  localparam int BCK                = 1;
  localparam int LFT                = 2;
  localparam int RGHT               = 3;
  localparam int ESC_MAX_PULSE_CLKS = 12391;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } esc_state_e;

endpackage

// File: rtl/esc_update_scheduler_if.sv
// esc_update_scheduler_if: bundle between the flight controller and the scheduler.
//   vld, frnt_spd, bck_spd, lft_spd, rght_spd : speed command and capture strobe
//   motors_off                                : level kill request
//   esc_spd, esc_wrt, armed                   : broadcast ESC write and arming status
// master = flight controller side, slave = scheduler side.
interface esc_update_scheduler_if;
  import esc_sched_pkg::*;

  logic                      vld;
  logic [SPD_W-1:0]          frnt_spd;
  logic [SPD_W-1:0]          bck_spd;
  logic [SPD_W-1:0]          lft_spd;
  logic [SPD_W-1:0]          rght_spd;
  logic                      motors_off;
  logic [3:0][SPD_W-1:0]     esc_spd;
  logic                      esc_wrt;
  logic                      armed;

  modport master (
    output vld, frnt_spd, bck_spd, lft_spd, rght_spd, motors_off,
    input  esc_spd, esc_wrt, armed
  );

  modport slave (
    input  vld, frnt_spd, bck_spd, lft_spd, rght_spd, motors_off,
    output esc_spd, esc_wrt, armed
  );

endinterface

// File: rtl/esc_update_scheduler_slew_step.sv
// esc_slew_step: combinational single-frame slew limiter for one motor.
//   cur  in  present speed
//   tgt  in  target speed
//   next out speed to write this frame: tgt, clamped to within MAX_STEP of cur
// Arithmetic is one bit wider than a speed so cur+MAX_STEP and tgt+MAX_STEP
// cannot wrap; the result always stays between cur and tgt, hence in range.
module esc_slew_step
  import esc_sched_pkg::*;
#(
  parameter int MAX_STEP = 64
) (
  input  logic [SPD_W-1:0] cur,
  input  logic [SPD_W-1:0] tgt,
  output logic [SPD_W-1:0] next
);

  localparam logic [SPD_W:0] STEP = (SPD_W+1)'(MAX_STEP);

  logic [SPD_W:0] cur_w;
  logic [SPD_W:0] tgt_w;

  assign cur_w = {1'b0, cur};
  assign tgt_w = {1'b0, tgt};

  // Clamp the per-frame change to MAX_STEP in either direction.
  always_comb begin
    next = tgt;
    if (tgt_w > cur_w + STEP) begin
      next = SPD_W'(cur_w + STEP);
    end else if (tgt_w + STEP < cur_w) begin
      next = SPD_W'(cur_w - STEP);
    end else begin
      next = tgt;
    end
  end

endmodule

// File: rtl/esc_update_scheduler.sv
// esc_update_scheduler: once-per-frame synchronized speed write to four ESCs.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  esc_update_scheduler_if.slave: speed commands, kill request,
//        esc_spd/esc_wrt broadcast write and armed status
// Optional feature: define ESC_SLEW_LIMIT_EN to limit each motor's change per
// frame to MAX_STEP (arming and kill zeros are never slew-limited). Without it
// the command is written directly and no slew logic exists.
module esc_update_scheduler
  import esc_sched_pkg::*;
#(
  parameter int FRAME_CLKS = 20000,
  parameter int ARM_FRAMES = 50,
  parameter int MAX_STEP   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  esc_update_scheduler_if.slave bus
);

  localparam int              CNT_W    = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CLKS - 1);
  localparam logic [7:0]      ARM_LIM  = 8'(ARM_FRAMES);

  if (FRAME_CLKS < 4) begin : g_bad_frame
    $error("FRAME_CLKS must be at least 4");
  end
  if (ARM_FRAMES < 1 || ARM_FRAMES > 255) begin : g_bad_arm
    $error("ARM_FRAMES must be in 1..255");
  end
  if (MAX_STEP < 1 || MAX_STEP > 2047) begin : g_bad_step
    $error("MAX_STEP must be in 1..2047");
  end
  // Frames shorter than the longest ESC pulse would cut pulses short; that is
  // only tolerable in simulation with tiny frames.
  if (FRAME_CLKS <= ESC_MAX_PULSE_CLKS) begin : g_short_frame
  end

  logic [CNT_W-1:0]      frame_cnt;
  logic                  tick;
  esc_state_e            state;
  esc_state_e            state_next;
  logic [7:0]            arm_cnt;
  logic [7:0]            arm_cnt_next;
  logic                  zero_wr;
  logic [3:0][SPD_W-1:0] cmd;
  logic [3:0][SPD_W-1:0] step_spd;
  logic [3:0][SPD_W-1:0] esc_spd;
  logic                  esc_wrt;
  logic                  armed;

  assign tick = (frame_cnt == {CNT_W{1'b0}});

  // Command capture; last strobe wins, accepted in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
    end else if (bus.vld) begin
      cmd[FRNT] <= bus.frnt_spd;
      cmd[BCK]  <= bus.bck_spd;
      cmd[LFT]  <= bus.lft_spd;
      cmd[RGHT] <= bus.rght_spd;
    end
  end

  // Frame counter: tick on count 0, reloading in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= CNT_LOAD;
    end else if (tick) begin
      frame_cnt <= CNT_LOAD;
    end else begin
      frame_cnt <= frame_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and arming-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARM;
      arm_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
    end
  end

  // Next state, arming count and whether this tick forces a zero write.
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    zero_wr      = 1'b1;
    if (tick) begin
      case (state)
        ARM: begin
          zero_wr = 1'b1;
          if (bus.motors_off) begin
            arm_cnt_next = 8'd0;
          end else begin
            arm_cnt_next = arm_cnt + 8'd1;
            if (arm_cnt_next == ARM_LIM) begin
              state_next = RUN;
            end else begin
              state_next = ARM;
            end
          end
        end
        RUN: begin
          if (bus.motors_off) begin
            state_next = KILL;
            zero_wr    = 1'b1;
          end else begin
            zero_wr    = 1'b0;
          end
        end
        KILL: begin
          if (bus.motors_off) begin
            zero_wr    = 1'b1;
          end else begin
            state_next = RUN;
            zero_wr    = 1'b0;
          end
        end
        default: begin
          state_next   = ARM;
          arm_cnt_next = 8'd0;
          zero_wr      = 1'b1;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

`ifdef ESC_SLEW_LIMIT_EN
  for (genvar i = 0; i < 4; i++) begin : g_step
    esc_slew_step #(.MAX_STEP(MAX_STEP)) u_step (
      .cur  (esc_spd[i]),
      .tgt  (cmd[i]),
      .next (step_spd[i])
    );
  end
`else
  assign step_spd = cmd;
`endif

  // Output registers: one write per tick; armed sticks after the first
  // tick seen outside ARM (KILL is only reachable through RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      esc_spd <= '0;
      esc_wrt <= 1'b0;
      armed   <= 1'b0;
    end else begin
      esc_wrt <= tick;
      if (tick) begin
        esc_spd <= zero_wr ? '0 : step_spd;
        if (state != ARM) begin
          armed <= 1'b1;
        end
      end
    end
  end

  assign bus.esc_spd = esc_spd;
  assign bus.esc_wrt = esc_wrt;
  assign bus.armed   = armed;

endmodule

// File: tb/tb_esc_update_scheduler.sv
// Self-checking bench for esc_update_scheduler with FRAME_CLKS=16,
// ARM_FRAMES=3, MAX_STEP=64. Expected speeds are hand-computed for the
// build in use (slew-limited or direct).
module tb_esc_update_scheduler;
  import esc_sched_pkg::*;

  localparam int FRAME = 16;
  localparam int ARMF  = 3;
  localparam int STEP  = 64;

  typedef logic [3:0][SPD_W-1:0] spd_t;
  typedef struct {
    logic do_vld;
    spd_t cmd;
    logic off;
    spd_t exp;
    logic exp_armed;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  esc_update_scheduler_if bus();

  esc_update_scheduler #(
    .FRAME_CLKS (FRAME),
    .ARM_FRAMES (ARMF),
    .MAX_STEP   (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle number: 0 is the first cycle after the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic spd_t s4(input int f, input int b, input int l, input int r);
    spd_t v;
    v[FRNT] = SPD_W'(f);
    v[BCK]  = SPD_W'(b);
    v[LFT]  = SPD_W'(l);
    v[RGHT] = SPD_W'(r);
    return v;
  endfunction

  function automatic vec_t mk(input logic v, input spd_t c, input logic o,
                              input spd_t e, input logic a);
    vec_t r;
    r.do_vld = v; r.cmd = c; r.off = o; r.exp = e; r.exp_armed = a;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic drive_cmd(input spd_t c);
    bus.frnt_spd = c[FRNT];
    bus.bck_spd  = c[BCK];
    bus.lft_spd  = c[LFT];
    bus.rght_spd = c[RGHT];
    bus.vld      = 1'b1;
    @(posedge clk);
    #1 bus.vld   = 1'b0;
  endtask

  task automatic wait_wrt(input string name, output int c);
    c = -1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.esc_wrt === 1'b1) begin
        c = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=no_write required=write_within_%0d_cycles", name, 2 * FRAME + 4);
  endtask

  vec_t vecs[$];
  int   c;
  int   exp_c;
  int   w;

  initial begin
    bus.vld = 1'b0; bus.motors_off = 1'b0;
    bus.frnt_spd = '0; bus.bck_spd = '0; bus.lft_spd = '0; bus.rght_spd = '0;

    // {vld, command, motors_off, expected esc_spd, expected armed}
    vecs.push_back(mk(1'b1, s4(500,500,500,500), 1'b0, s4(0,0,0,0), 1'b0));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(0,0,0,0), 1'b0));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(0,0,0,0), 1'b0));
`ifdef ESC_SLEW_LIMIT_EN
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(64,64,64,64),     1'b1));
    vecs.push_back(mk(1'b1, s4(200,64,0,100),    1'b0, s4(128,64,0,100),    1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(192,64,0,100),    1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(200,64,0,100),    1'b1));
    vecs.push_back(mk(1'b1, s4(0,64,0,100),      1'b0, s4(136,64,0,100),    1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(72,64,0,100),     1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(8,64,0,100),      1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(0,64,0,100),      1'b1));
    vecs.push_back(mk(1'b1, s4(1000,1000,1000,1000), 1'b0, s4(64,128,64,164), 1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b1, s4(0,0,0,0),         1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(64,64,64,64),     1'b1));
`else
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(500,500,500,500), 1'b1));
    vecs.push_back(mk(1'b1, s4(100,200,300,400), 1'b0, s4(100,200,300,400), 1'b1));
    vecs.push_back(mk(1'b1, s4(0,0,0,0),         1'b0, s4(0,0,0,0),         1'b1));
    vecs.push_back(mk(1'b1, s4(2047,2047,0,5),   1'b0, s4(2047,2047,0,5),   1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b1, s4(0,0,0,0),         1'b1));
    vecs.push_back(mk(1'b1, s4(7,8,9,10),        1'b1, s4(0,0,0,0),         1'b1));
    vecs.push_back(mk(1'b0, s4(0,0,0,0),         1'b0, s4(7,8,9,10),        1'b1));
`endif

    // Reset, then check reset values in cycle 0.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_esc_spd", 64'(bus.esc_spd), 64'(s4(0,0,0,0)));
    chk("reset_esc_wrt", 64'(bus.esc_wrt), 64'd0);
    chk("reset_armed",   64'(bus.armed),   64'd0);

    // Table: arming, steady running, slew and kill/release.
    exp_c = FRAME;
    foreach (vecs[i]) begin
      if (vecs[i].do_vld) drive_cmd(vecs[i].cmd);
      bus.motors_off = vecs[i].off;
      wait_wrt($sformatf("vec%0d", i), c);
      if (c >= 0) begin
        chk($sformatf("vec%0d_cycle", i), 64'(c), 64'(exp_c));
        chk($sformatf("vec%0d_spd", i), 64'(bus.esc_spd), 64'(vecs[i].exp));
        chk($sformatf("vec%0d_armed", i), 64'(bus.armed), 64'(vecs[i].exp_armed));
        exp_c = c + FRAME;
      end else begin
        exp_c = exp_c + FRAME;
      end
    end

    // Command captured in the tick cycle must not affect that tick's write.
    drive_cmd(s4(100,100,100,100));
    wait_wrt("pre_tick", c);
    w = c;
    chk("pre_tick_spd", 64'(bus.esc_spd), 64'(s4(100,100,100,100)));
    repeat (FRAME - 1) @(posedge clk);
    #1;
    drive_cmd(s4(300,300,300,300));
    chk("tick_vld_wrt",   64'(bus.esc_wrt), 64'd1);
    chk("tick_vld_cycle", 64'(cyc), 64'(w + FRAME));
    chk("tick_vld_spd",   64'(bus.esc_spd), 64'(s4(100,100,100,100)));
    @(posedge clk);
    #1;
    chk("wrt_one_cycle", 64'(bus.esc_wrt), 64'd0);
    wait_wrt("after_tick_vld", c);
`ifdef ESC_SLEW_LIMIT_EN
    chk("after_tick_vld_spd", 64'(bus.esc_spd), 64'(s4(164,164,164,164)));
`else
    chk("after_tick_vld_spd", 64'(bus.esc_spd), 64'(s4(300,300,300,300)));
`endif

    // One-cycle reset mid-frame; motors_off held through the first tick
    // restarts arming, so RUN is reached one frame later than usual.
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    bus.motors_off = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_spd",   64'(bus.esc_spd), 64'(s4(0,0,0,0)));
    chk("midrst_armed", 64'(bus.armed),   64'd0);
    chk("midrst_wrt",   64'(bus.esc_wrt), 64'd0);
    wait_wrt("rearm0", c);
    chk("rearm0_cycle", 64'(c), 64'(FRAME));
    chk("rearm0_spd",   64'(bus.esc_spd), 64'(s4(0,0,0,0)));
    bus.motors_off = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wait_wrt($sformatf("rearm%0d", k), c);
      chk($sformatf("rearm%0d_cycle", k), 64'(c), 64'(k * FRAME));
      chk($sformatf("rearm%0d_spd", k), 64'(bus.esc_spd), 64'(s4(0,0,0,0)));
      chk($sformatf("rearm%0d_armed", k), 64'(bus.armed), (k == 5) ? 64'd1 : 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esc_update_scheduler.md
# esc_update_scheduler

Frame scheduler that sits between the flight controller and the four ESC PWM interfaces. It latches commanded motor speeds, holds all motors at zero through a post-reset arming period and honours a motors-off kill. Once per frame it broadcasts one synchronized write of four (optionally slew-limited) speeds, so ESC pulses restart only on frame boundaries.

## Interface
- FRAME_CLKS, 20000: clocks per update frame. Production builds use ≥ 12400, which exceeds the longest ESC pulse of 6250 + 3·2047 clocks. Benches may use any value ≥ 4.
- ARM_FRAMES, 50: number of zero-speed frames written after reset before commands are honoured; legal range 1 to 255.
- MAX_STEP, 64: maximum per-frame change of any motor speed when slew limiting is compiled in; legal range 1 to 2047.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- vld  in  1  single-cycle strobe: capture the four speed inputs this cycle.
- frnt_spd, bck_spd, lft_spd, rght_spd  in  11 each  commanded speeds, unsigned.
- motors_off  in  1  level kill request, sampled at frame ticks.
- esc_spd  out  4×11 (packed [3:0][10:0])  speed presented to each ESC; index order comes from the package.
- esc_wrt  out  1  one-cycle write strobe, shared by all four ESCs.
- armed  out  1  high once arming is complete.

## Operation
- Command registers: on `vld`, all four speed inputs are captured. Captures are accepted in every state; the last capture wins.
- Frame counter:
  - Reset loads FRAME_CLKS−1; the counter then decrements every cycle.
  - `tick` is the cycle in which the count is 0; on that cycle the counter reloads FRAME_CLKS−1.
- States: ARM, RUN, KILL. Reset enters ARM.
  - ARM: every tick targets 0 for all motors and increments `arm_cnt`.
    - If `motors_off`=1 at a tick, `arm_cnt` clears to 0 (arming restarts).
    - At the tick where `arm_cnt` reaches ARM_FRAMES, the state moves to RUN. That tick still writes 0.
  - RUN: each tick moves every motor toward its command register.
    - If `motors_off`=1 at a tick, the state moves to KILL and that tick writes 0 to all motors immediately, bypassing slew.
  - KILL: every tick writes 0.
    - At a tick with `motors_off`=0, the state moves to RUN and that same tick moves each motor from 0 toward its command.
- Speed arithmetic (per motor, 12-bit internal): cur = present esc_spd, tgt = target.
  - If tgt > cur + MAX_STEP, next = cur + MAX_STEP.
  - Else if tgt + MAX_STEP < cur, next = cur − MAX_STEP.
  - Otherwise next = tgt.
  - No wrap-around: the result always lies in [0, 2047].
- `esc_wrt` pulses on every tick in every state, so the ESCs are written every frame even when the value is unchanged.

## Timing
- Reset values: esc_spd=0, esc_wrt=0, armed=0, state ARM, command registers 0, arm_cnt 0.
- Reset mid-frame takes effect at the next edge. `esc_wrt` is never high in the cycle following a reset cycle.
- Cycle numbering: cycle 0 is the first cycle with rst=0.
  - The first tick is cycle FRAME_CLKS−1.
  - On the next edge, `esc_spd` updates and `esc_wrt`=1 for exactly that one cycle (cycle FRAME_CLKS).
- Tick spacing is FRAME_CLKS cycles. `esc_spd` is stable from one write to the next.
- `vld` in the tick cycle: the new command is not used by that tick. It applies from the next frame.
- `armed` rises in the cycle of the first RUN write, i.e. together with that write's `esc_wrt`, and stays high until reset. `armed` stays 1 in KILL.
- Kill latency: at most one frame plus one cycle from `motors_off` assertion to the zero write.

## Configuration
- `ESC_SLEW_LIMIT_EN` defined: per-motor MAX_STEP limiting as above, except that kill and arming zeros bypass it.
- Undefined: next = tgt on every tick, MAX_STEP is ignored, and no slew logic is synthesized.

## Structure
- Package `esc_sched_pkg`:
  - state enum {ARM, RUN, KILL};
  - motor index constants FRNT=0, BCK=1, LFT=2, RGHT=3;
  - SPD_W=11;
  - ESC_MAX_PULSE_CLKS=12391.
- One sub-module, `esc_slew_step`: combinational cur/tgt/MAX_STEP → next. It is instantiated four times, inside the `ESC_SLEW_LIMIT_EN` guard.

## Test plan
- Reset/arm, with FRAME_CLKS=16, ARM_FRAMES=3, and `vld` with all inputs 500:
  - esc_wrt pulses at cycles 16, 32 and 48 with esc_spd=0;
  - armed=1 at cycle 64, with esc_spd stepping to 64.
- Slew with MAX_STEP=64, motor at 0, command 200: successive writes are 64, 128, 192, 200.
  - A subsequent command of 0 gives writes of 136, 72, 8, 0.
- Kill in RUN at 1000: motors_off=1 gives a zero write at the next tick with armed=1.
  - Releasing motors_off gives 64 at the following write.
- `vld` coincident with tick, command 300 replacing 100 (motor already at 100): that write is 100; the next write moves toward 300.
- Reset asserted for one cycle mid-frame, with motors running: all outputs return to 0, armed=0, and the arming sequence restarts from cycle 0.
- Macro undefined: command 2047 from 0 produces a single write of 2047; no intermediate values.
